// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer with a return-address stack.
// Optional nesting of interrupts is enabled by defining INT_NEST_EN.
module int_sequencer #(
    parameter int unsigned pcWidth    = 8,
    parameter int unsigned stackDepth = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               intPending,
    input  logic [pcWidth-1:0] isrAddr,
    input  logic               instrDone,
    input  logic [pcWidth-1:0] curPC,
    input  logic               retI,
    output logic               clrPend,
    output logic               intDisable,
    output logic               ldPC,
    output logic [pcWidth-1:0] pcOut,
    output logic               inISR,
    output logic               stkErr
);

    localparam int unsigned DW = $clog2(stackDepth + 1);
    localparam int unsigned AW = $clog2(stackDepth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_VECTOR,
        S_ISR,
        S_RETURN
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [pcWidth-1:0] vec_q, vec_d;
    logic [pcWidth-1:0] pc_out_q, pc_out_d;
    logic [pcWidth-1:0] stk_q [stackDepth];
    logic               clr_pend_q, clr_pend_d;
    logic               ld_pc_q, ld_pc_d;
    logic               int_dis_q, int_dis_d;
    logic               in_isr_q, in_isr_d;
    logic               stk_err_q, stk_err_d;
    logic               push_c;
    logic               entry_c;
    logic [AW-1:0]      push_idx_c;
    logic [AW-1:0]      pop_idx_c;

    assign entry_c    = intPending & instrDone;
    assign push_idx_c = depth_q[AW-1:0];
    assign pop_idx_c  = AW'(depth_q - DW'(1));

    // State register and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            depth_q    <= '0;
            vec_q      <= '0;
            pc_out_q   <= '0;
            clr_pend_q <= 1'b0;
            ld_pc_q    <= 1'b0;
            int_dis_q  <= 1'b0;
            in_isr_q   <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            vec_q      <= vec_d;
            pc_out_q   <= pc_out_d;
            clr_pend_q <= clr_pend_d;
            ld_pc_q    <= ld_pc_d;
            int_dis_q  <= int_dis_d;
            in_isr_q   <= in_isr_d;
            stk_err_q  <= stk_err_d;
        end
    end

    // Return-address stack storage
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < stackDepth; i++) begin
                stk_q[i] <= '0;
            end
        end else if (push_c) begin
            stk_q[push_idx_c] <= curPC;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        vec_d     = vec_q;
        pc_out_d  = pc_out_q;
        stk_err_d = stk_err_q;
        push_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (retI) begin
                    stk_err_d = 1'b1;
                end
                if (entry_c && !int_dis_q) begin
                    push_c  = 1'b1;
                    vec_d   = isrAddr;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                pc_out_d = vec_q;
                state_d  = S_VECTOR;
            end
            S_VECTOR: begin
                state_d = S_ISR;
            end
            S_ISR: begin
                // A return always beats a simultaneous new entry.
                if (retI) begin
                    pc_out_d = stk_q[pop_idx_c];
                    depth_d  = depth_q - DW'(1);
                    state_d  = S_RETURN;
                end
`ifdef INT_NEST_EN
                else if (entry_c) begin
                    if (depth_q < DW'(stackDepth)) begin
                        push_c  = 1'b1;
                        vec_d   = isrAddr;
                        state_d = S_ACK;
                    end else begin
                        stk_err_d = 1'b1;
                    end
                end
`endif
            end
            S_RETURN: begin
                state_d = (depth_q == '0) ? S_IDLE : S_ISR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            depth_d = depth_q + DW'(1);
        end

        clr_pend_d = (state_d == S_ACK);
        ld_pc_d    = (state_d == S_VECTOR) || (state_d == S_RETURN);
        in_isr_d   = (depth_d != '0);
`ifdef INT_NEST_EN
        int_dis_d  = (state_d == S_ACK) || (state_d == S_VECTOR) ||
                     (state_d == S_RETURN) ||
                     ((state_d == S_ISR) && (depth_d == DW'(stackDepth)));
`else
        int_dis_d  = (state_d == S_ACK) || (state_d == S_VECTOR) ||
                     (state_d == S_RETURN) || (state_d == S_ISR);
`endif
    end

    assign clrPend    = clr_pend_q;
    assign intDisable = int_dis_q;
    assign ldPC       = ld_pc_q;
    assign pcOut      = pc_out_q;
    assign inISR      = in_isr_q;
    assign stkErr     = stk_err_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer (default build; nesting
// scenario included when INT_NEST_EN is defined).
module tb_int_sequencer;

    logic       clk;
    logic       clr;
    logic       intPending;
    logic [7:0] isrAddr;
    logic       instrDone;
    logic [7:0] curPC;
    logic       retI;
    logic       clrPend;
    logic       intDisable;
    logic       ldPC;
    logic [7:0] pcOut;
    logic       inISR;
    logic       stkErr;

    int checks = 0;
    int errors = 0;

    int_sequencer #(.pcWidth(8), .stackDepth(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .intPending (intPending),
        .isrAddr    (isrAddr),
        .instrDone  (instrDone),
        .curPC      (curPC),
        .retI       (retI),
        .clrPend    (clrPend),
        .intDisable (intDisable),
        .ldPC       (ldPC),
        .pcOut      (pcOut),
        .inISR      (inISR),
        .stkErr     (stkErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs all outputs: {clrPend, ldPC, intDisable, inISR, stkErr, pcOut}
    function automatic logic [12:0] outs();
        return {clrPend, ldPC, intDisable, inISR, stkErr, pcOut};
    endfunction

    initial begin
        clr = 1'b1; intPending = 1'b0; instrDone = 1'b0; retI = 1'b0;
        curPC = 8'h00; isrAddr = 8'h00;
        tick();
        check("reset_outputs", 32'(outs()), 32'h0);
        clr = 1'b0;
        tick();
        check("idle_outputs", 32'(outs()), 32'h0);

        // Basic entry and return
        intPending = 1'b1; instrDone = 1'b1; curPC = 8'h20; isrAddr = 8'h80;
        tick();
        check("ack_clrpend", 32'(clrPend), 32'h1);
        check("ack_ldpc", 32'(ldPC), 32'h0);
        check("ack_intdis", 32'(intDisable), 32'h1);
        check("ack_inisr", 32'(inISR), 32'h1);
        intPending = 1'b0; instrDone = 1'b0;
        tick();
        check("vec_clrpend", 32'(clrPend), 32'h0);
        check("vec_ldpc", 32'(ldPC), 32'h1);
        check("vec_pcout", 32'(pcOut), 32'h80);
        tick();
        check("isr_ldpc", 32'(ldPC), 32'h0);
        check("isr_pcout_hold", 32'(pcOut), 32'h80);
        check("isr_inisr", 32'(inISR), 32'h1);
`ifdef INT_NEST_EN
        check("isr_intdis", 32'(intDisable), 32'h0);
`else
        check("isr_intdis", 32'(intDisable), 32'h1);
`endif
        retI = 1'b1;
        tick();
        retI = 1'b0;
        check("ret_ldpc", 32'(ldPC), 32'h1);
        check("ret_pcout", 32'(pcOut), 32'h20);
        check("ret_inisr", 32'(inISR), 32'h0);
        check("ret_intdis", 32'(intDisable), 32'h1);
        tick();
        check("idle_after_ret", 32'(outs()), 32'h0020);

        // Pending without instruction boundary: must wait
        intPending = 1'b1; instrDone = 1'b0; curPC = 8'h30; isrAddr = 8'h44;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_no_ack", 32'({clrPend, ldPC}), 32'h0);
        end
        instrDone = 1'b1;
        tick();
        check("wait_then_ack", 32'(clrPend), 32'h1);
        intPending = 1'b0; instrDone = 1'b0;
        tick();
        check("wait_vec", 32'({ldPC, pcOut}), 32'h144);
        tick();

        // retI and new entry together in ISR: return wins, entry follows
        retI = 1'b1; intPending = 1'b1; instrDone = 1'b1; curPC = 8'h31; isrAddr = 8'h55;
        tick();
        retI = 1'b0;
        check("race_return", 32'({clrPend, ldPC, pcOut}), 32'h130);
        tick();
        check("race_idle", 32'({clrPend, ldPC, intDisable, inISR}), 32'h0);
        tick();
        check("race_ack", 32'({clrPend, inISR}), 32'h3);
        intPending = 1'b0; instrDone = 1'b0;
        tick();
        check("race_vec", 32'({ldPC, pcOut}), 32'h155);
        tick();
        retI = 1'b1;
        tick();
        retI = 1'b0;
        check("race_ret2", 32'({ldPC, pcOut}), 32'h131);
        tick();
        check("race_idle2", 32'(outs()), 32'h0031);

        // retI at depth 0
        retI = 1'b1;
        tick();
        retI = 1'b0;
        check("underflow", 32'(outs()), 32'h0131);
        tick();
        check("underflow_sticky", 32'(outs()), 32'h0131);

        // Reset in the middle of an entry sequence
        intPending = 1'b1; instrDone = 1'b1; curPC = 8'h66; isrAddr = 8'h77;
        tick();
        check("mid_ack", 32'(clrPend), 32'h1);
        clr = 1'b1; intPending = 1'b0; instrDone = 1'b0;
        #2;
        check("mid_async_clear", 32'(outs()), 32'h0);
        clr = 1'b0;
        tick();
        check("mid_after_clr", 32'(outs()), 32'h0);
        tick();
        check("mid_no_ldpc", 32'(outs()), 32'h0);

`ifdef INT_NEST_EN
        // Four nested entries, refused fifth, four returns
        for (int i = 0; i < 4; i++) begin
            intPending = 1'b1; instrDone = 1'b1;
            curPC = 8'(8'h10 + i); isrAddr = 8'(8'h90 + i);
            tick();
            check("nest_ack", 32'(clrPend), 32'h1);
            intPending = 1'b0; instrDone = 1'b0;
            tick();
            check("nest_vec", 32'({ldPC, pcOut}), 32'(9'h100 + 9'h90 + 9'(i)));
            tick();
            check("nest_intdis", 32'(intDisable), (i == 3) ? 32'h1 : 32'h0);
        end
        intPending = 1'b1; instrDone = 1'b1; curPC = 8'h14; isrAddr = 8'h94;
        tick();
        check("nest_overflow", 32'({stkErr, clrPend, ldPC}), 32'h4);
        tick();
        check("nest_overflow_hold", 32'({stkErr, clrPend, ldPC}), 32'h4);
        intPending = 1'b0; instrDone = 1'b0;
        for (int k = 0; k < 4; k++) begin
            retI = 1'b1;
            tick();
            retI = 1'b0;
            check("nest_ret_pc", 32'({ldPC, pcOut}), 32'(9'h100 + 9'h13 - 9'(k)));
            tick();
            check("nest_ret_inisr", 32'(inISR), (k < 3) ? 32'h1 : 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 SHALL have parameter pcWidth, default 8, giving the width of PC and ISR addresses.
REQ-002 SHALL have parameter stackDepth, default 4, giving the number of return-address entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port intPending  input  1  pending-interrupt flag from the interrupt priority system.
REQ-006 SHALL have port isrAddr  input  pcWidth  ISR vector address from the interrupt priority system.
REQ-007 SHALL have port instrDone  input  1  the current instruction has completed (interrupt-safe boundary).
REQ-008 SHALL have port curPC  input  pcWidth  address of the next instruction (the return address).
REQ-009 SHALL have port retI  input  1  a return-from-interrupt instruction is executing (one-cycle pulse).
REQ-010 SHALL have port clrPend  output  1  one-cycle pulse that clears the pending flag upstream.
REQ-011 SHALL have port intDisable  output  1  masks further intPending upstream.
REQ-012 SHALL have port ldPC  output  1  one-cycle request to load the PC with pcOut.
REQ-013 SHALL have port pcOut  output  pcWidth  target PC value (ISR vector or return address).
REQ-014 SHALL have port inISR  output  1  high whenever the stack depth is nonzero.
REQ-015 SHALL have port stkErr  output  1  sticky stack overflow/underflow error.

Function
REQ-016 SHALL implement the states IDLE, ACK, VECTOR, ISR and RETURN, with all outputs registered.
REQ-017 IDLE: when intPending & instrDone & ~intDisable, SHALL push curPC, latch isrAddr into the vector register and go to ACK.
REQ-018 ACK: SHALL assert clrPend for exactly one cycle, then go to VECTOR.
REQ-019 VECTOR: SHALL assert ldPC with pcOut equal to the latched vector for one cycle, then go to ISR.
REQ-020 Latency SHALL be: entry condition sampled at edge N -> clrPend high in cycle N+1 -> ldPC high in cycle N+2.
REQ-021 ISR: on retI SHALL pop the top entry to pcOut and go to RETURN.
REQ-022 RETURN: SHALL assert ldPC for one cycle, then go to IDLE if the depth is now 0, otherwise to ISR.
REQ-023 When retI and an entry condition occur in the same cycle in ISR, retI SHALL win and the interrupt SHALL stay pending.
REQ-024 retI in IDLE (depth 0) SHALL be ignored apart from setting stkErr; no ldPC and no state change.
REQ-025 The depth counter SHALL range 0..stackDepth, with no wrap-around.
REQ-026 A push at depth == stackDepth SHALL be refused: stkErr is set, the stack is unchanged and the FSM stays put.
REQ-027 intDisable SHALL be high in ACK, VECTOR and RETURN, and governed by REQ-030/031 in ISR.
REQ-028 pcOut SHALL hold its last value when ldPC is low.

Reset
REQ-029 On clr high, asynchronously and regardless of state: state=IDLE, depth=0, all stack entries, the vector register and pcOut =0, clrPend=ldPC=intDisable=inISR=stkErr=0; mid-sequence reset SHALL discard any pending push or pop.

Configuration
REQ-030 With INT_NEST_EN defined, ISR SHALL accept a new entry (same rules as IDLE, go to ACK) while depth < stackDepth, and intDisable SHALL be low in ISR while depth < stackDepth.
REQ-031 Without INT_NEST_EN, the effective depth SHALL be 1, intDisable SHALL be high throughout ISR, and no nested entry is possible.

Verification
REQ-032 Reset, then intPending=1, instrDone=1, curPC=0x20, isrAddr=0x80 -> clrPend at N+1, ldPC with pcOut=0x80 at N+2, inISR=1; then retI -> ldPC with pcOut=0x20, state IDLE, inISR=0.
REQ-033 intPending=1 with instrDone=0 for 5 cycles -> no clrPend and no ldPC until instrDone=1.
REQ-034 With INT_NEST_EN: nest 4 interrupts (return addresses 0x10, 0x11, 0x12, 0x13), then attempt a 5th -> stkErr=1 and no ACK; four retI -> pcOut sequence 0x13, 0x12, 0x11, 0x10.
REQ-035 retI at depth 0 -> stkErr=1, ldPC stays 0, state IDLE.
REQ-036 In ISR, retI and intPending asserted in the same cycle -> RETURN taken; the interrupt is acknowledged after the return (without INT_NEST_EN, from IDLE).
REQ-037 clr pulsed in cycle N+1 of an entry sequence -> no ldPC, depth=0, all outputs 0 the next cycle.
